reg_file_sb: RTL and testbench

- Parametrised multi-register file with 2 read ports and 1 write port, plus a per-register scoreboard (busy bit).
- Next-generation CPU register file: sits between decode (read operands, reserve destination) and writeback (write result, clear busy).
- Reads are registered, with write-first bypass.
- Read and write proceed in the same cycle, independently.

---
 rtl/reg_file_pkg.sv | 28 ++
 rtl/reg_file_scoreboard.sv | 53 +++++
 rtl/reg_file_sb.sv | 124 ++++++++++++
 tb/tb_reg_file_sb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
//==============================================================================
// Module   : reg_file_pkg
// Desc     : Shared widths and preset reset table for the reg_file_sb block.
// Macro    : RF_INIT_EN (selects the preset table as register reset values)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package reg_file_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int PRESET_N   = 8;

   localparam logic [31:0] RESET_TABLE [PRESET_N] = '{
      32'd10, 32'd1000, 32'd100, 32'd1, 32'd10000, 32'd0, 32'd500, 32'd5000
   };

   // Registers beyond the preset table reset to zero.
   function automatic logic [31:0] reset_val(input int unsigned idx);
      if (idx < PRESET_N)
         return RESET_TABLE[idx[2:0]];
      return 32'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
//==============================================================================
// Module   : reg_file_scoreboard
// Desc     : Per-register busy bits; reserve sets, writeback clears, set wins.
// Macro    : none
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_en,
   input  logic [ADDR_W-1:0]      set_addr,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_addr,
   output logic [2**ADDR_W-1:0]   busy_next,
   output logic [2**ADDR_W-1:0]   busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_q;

   always_comb begin
      busy_d = busy_q;
      if (clr_en)
         busy_d[clr_addr] = 1'b0;
      // A reservation in the same cycle as writeback belongs to a newer producer.
      if (set_en)
         busy_d[set_addr] = 1'b1;
      if (ZERO_REG != 0)
         busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy_next = busy_d;
   assign busy_vec  = busy_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
//==============================================================================
// Module   : reg_file_sb
// Desc     : 2R/1W register file with registered write-first reads and a
//            per-register busy scoreboard.
// Macro    : RF_INIT_EN (reset loads reg_file_pkg preset table instead of zero)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr_a,
   input  logic [ADDR_W-1:0]      rd_addr_b,
   output logic [DATA_W-1:0]      rd_data_a,
   output logic [DATA_W-1:0]      rd_data_b,
   output logic                   rd_busy_a,
   output logic                   rd_busy_b,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rsv_en,
   input  logic [ADDR_W-1:0]      rsv_addr,
   output logic [2**ADDR_W-1:0]   busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [DATA_W-1:0]   mem_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_next;
   logic                wr_ok;

   logic [DATA_W-1:0]   rd_data_a_d, rd_data_a_q;
   logic [DATA_W-1:0]   rd_data_b_d, rd_data_b_q;
   logic                rd_busy_a_d, rd_busy_a_q;
   logic                rd_busy_b_d, rd_busy_b_q;

   assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

   reg_file_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (rsv_en),
      .set_addr  (rsv_addr),
      .clr_en    (wr_en),
      .clr_addr  (wr_addr),
      .busy_next (busy_next),
      .busy_vec  (busy_vec)
   );

   always_comb begin
      mem_d = mem_q;
      if (wr_ok)
         mem_d[wr_addr] = wr_data;
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
`ifdef RF_INIT_EN
         localparam logic [DATA_W-1:0] c_rst_val =
            ((ZERO_REG != 0) && (i == 0)) ? '0 : DATA_W'(reset_val(i));
`else
         localparam logic [DATA_W-1:0] c_rst_val = '0;
`endif
         logic [DATA_W-1:0] reg_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               reg_q <= c_rst_val;
            else
               reg_q <= mem_d[i];
         end

         assign mem_q[i] = reg_q;
      end
   endgenerate

   // mem_d/busy_next already hold post-edge state, which gives write-first bypass.
   always_comb begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      rd_busy_a_d = rd_busy_a_q;
      rd_busy_b_d = rd_busy_b_q;
      if (rd_en) begin
         rd_data_a_d = mem_d[rd_addr_a];
         rd_data_b_d = mem_d[rd_addr_b];
         rd_busy_a_d = busy_next[rd_addr_a];
         rd_busy_b_d = busy_next[rd_addr_b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_busy_a_q <= 1'b0;
         rd_busy_b_q <= 1'b0;
      end else begin
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_busy_a_q <= rd_busy_a_d;
         rd_busy_b_q <= rd_busy_b_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_busy_a = rd_busy_a_q;
   assign rd_busy_b = rd_busy_b_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//==============================================================================
// Module   : tb_reg_file_sb
// Desc     : Self-checking bench for reg_file_sb, ZERO_REG=0 and ZERO_REG=1.
// Macro    : RF_INIT_EN (changes the expected reset contents)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_file_sb;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_en, wr_en, rsv_en;
   logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] da0, db0, da1, db1;
   logic          ba0, bb0, ba1, bb1;
   logic [NR-1:0] bv0, bv1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state, index 0 = ZERO_REG off, 1 = ZERO_REG on.
   int m_mem  [2][NR];
   bit m_busy [2][NR];
   int m_rda  [2];
   int m_rdb  [2];
   bit m_ba   [2];
   bit m_bb   [2];

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(da0), .rd_data_b(db0), .rd_busy_a(ba0), .rd_busy_b(bb0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv0)
   );

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(da1), .rd_data_b(db1), .rd_busy_a(ba1), .rd_busy_b(bb1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv1)
   );

   function automatic int init_val(int zr, int i);
      int tbl [8];
      tbl = '{10, 1000, 100, 1, 10000, 0, 500, 5000};
`ifdef RF_INIT_EN
      if (zr != 0 && i == 0)
         return 0;
      return tbl[i] & 32'hFFFF;
`else
      return (tbl[i] & 0) + zr * 0;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NR; i++) begin
            m_mem[k][i]  = init_val(k, i);
            m_busy[k][i] = 1'b0;
         end
         m_rda[k] = 0; m_rdb[k] = 0; m_ba[k] = 1'b0; m_bb[k] = 1'b0;
      end
   endtask

   // Applies one clock edge's worth of architectural effects to the model.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (wr_en && !(k == 1 && wr_addr == 0)) begin
            m_mem[k][wr_addr]  = int'(wr_data);
            m_busy[k][wr_addr] = 1'b0;
         end
         if (rsv_en && !(k == 1 && rsv_addr == 0))
            m_busy[k][rsv_addr] = 1'b1;
         if (rd_en) begin
            m_rda[k] = (k == 1 && rd_addr_a == 0) ? 0 : m_mem[k][rd_addr_a];
            m_rdb[k] = (k == 1 && rd_addr_b == 0) ? 0 : m_mem[k][rd_addr_b];
            m_ba[k]  = (k == 1 && rd_addr_a == 0) ? 1'b0 : m_busy[k][rd_addr_a];
            m_bb[k]  = (k == 1 && rd_addr_b == 0) ? 1'b0 : m_busy[k][rd_addr_b];
         end
      end
   endtask

   function automatic logic [NR-1:0] model_bv(int k);
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++)
         v[i] = m_busy[k][i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".d0.rda"}, 32'(da0), 32'(m_rda[0]));
      chk({tag, ".d0.rdb"}, 32'(db0), 32'(m_rdb[0]));
      chk({tag, ".d0.ba"},  32'(ba0), 32'(m_ba[0]));
      chk({tag, ".d0.bb"},  32'(bb0), 32'(m_bb[0]));
      chk({tag, ".d0.bv"},  32'(bv0), 32'(model_bv(0)));
      chk({tag, ".d1.rda"}, 32'(da1), 32'(m_rda[1]));
      chk({tag, ".d1.rdb"}, 32'(db1), 32'(m_rdb[1]));
      chk({tag, ".d1.ba"},  32'(ba1), 32'(m_ba[1]));
      chk({tag, ".d1.bb"},  32'(bb1), 32'(m_bb[1]));
      chk({tag, ".d1.bv"},  32'(bv1), 32'(model_bv(1)));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      rd_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
      rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
   endtask

   initial begin
      logic [DW-1:0] exp_r2, exp_r7;
`ifdef RF_INIT_EN
      exp_r2 = 16'd100;  exp_r7 = 16'd5000;
`else
      exp_r2 = 16'd0;    exp_r7 = 16'd0;
`endif
      idle();
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      #10;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset contents via a read of r2 / r7
      rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd7;
      tick("init_rd");
      chk("init_r2", 32'(da0), 32'(exp_r2));
      chk("init_r7", 32'(db0), 32'(exp_r7));
      chk("init_bv", 32'(bv0), 32'd0);

      // Write then read one cycle later, then hold
      idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234;
      tick("wr_r4");
      idle(); rd_en = 1'b1; rd_addr_a = 3'd4;
      tick("rd_r4");
      chk("rd_r4_val", 32'(da0), 32'h1234);
      idle(); rd_addr_a = 3'd1;
      tick("hold1");
      tick("hold2");
      chk("hold_r4", 32'(da0), 32'h1234);

      // Same-cycle bypass on both ports
      idle(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
      rd_en = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
      tick("byp");
      chk("byp_a", 32'(da0), 32'hBEEF);
      chk("byp_b", 32'(db0), 32'hBEEF);
      chk("byp_busy", 32'({ba0, bb0}), 32'd0);

      // Scoreboard reserve / write collision / clear
      idle(); rsv_en = 1'b1; rsv_addr = 3'd3; rd_en = 1'b1; rd_addr_a = 3'd3;
      tick("rsv3");
      chk("rsv3_busy", 32'(ba0), 32'd1);
      chk("rsv3_bv", 32'(bv0[3]), 32'd1);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h0033;
      tick("rsv_wr3");
      chk("rsv_wr3_busy", 32'(ba0), 32'd1);
      chk("rsv_wr3_data", 32'(da0), 32'h0033);
      rsv_en = 1'b0; wr_data = 16'h0044;
      tick("wr3");
      chk("wr3_busy", 32'(ba0), 32'd0);
      chk("wr3_bv", 32'(bv0[3]), 32'd0);

      // Hardwired zero register
      idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
      rsv_en = 1'b1; rsv_addr = 3'd0; rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      tick("zr_wr");
      chk("zr_byp", 32'(da1), 32'd0);
      chk("zr_bv0", 32'(bv1[0]), 32'd0);
      chk("nz_byp", 32'(da0), 32'hFFFF);
      idle(); rd_en = 1'b1; rd_addr_a = 3'd0;
      tick("zr_rd");
      chk("zr_rd_val", 32'(da1), 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rd_en     = 1'($urandom_range(0, 3) != 0);
         wr_en     = 1'($urandom_range(0, 1));
         rsv_en    = 1'($urandom_range(0, 2) == 0);
         rd_addr_a = AW'($urandom);
         rd_addr_b = AW'($urandom);
         wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom);
         rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
         wr_data   = DW'($urandom);
         tick("rand");
      end

      // Asynchronous reset in the middle of a cycle
      idle(); rsv_en = 1'b1; rsv_addr = 3'd1; rd_en = 1'b1; rd_addr_a = 3'd1;
      tick("pre_rst1");
      rsv_addr = 3'd2; rd_addr_b = 3'd2;
      tick("pre_rst2");
      rsv_addr = 3'd6; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
      tick("pre_rst3");
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_bv", 32'(bv0), 32'd0);
      chk("async_rda", 32'(da0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_en = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd2;
      tick("post_rst");
      chk("post_rst_r7", 32'(da0), 32'(exp_r7));
      chk("post_rst_r2", 32'(db0), 32'(exp_r2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
